// File: rtl/synth_pkg.sv
// Shared types and defaults for the synth audio path (keyboard, wavetable, envelope).
// Holds the envelope state encoding, the ENV_MAX helper and the default step sizes.
package synth_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } env_state_t;

    localparam int DEF_SAMPLE_W      = 16;
    localparam int DEF_ENV_W         = 16;
    localparam int DEF_ATTACK_STEP   = 16384;
    localparam int DEF_DECAY_STEP    = 8192;
    localparam int DEF_SUSTAIN_LVL   = 49152;
    localparam int DEF_RELEASE_STEP  = 16384;
    localparam int DEF_RELEASE_SHIFT = 6;

    // Full-scale envelope value for a given envelope width.
    function automatic longint unsigned envMax(input int envW);
        return (64'd1 << envW) - 64'd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Key and sample signals between the keyboard/wavetable side and the ADSR envelope.
// The driver side uses the master modport; the envelope block uses the slave modport.
interface adsr_envelope_if
    import synth_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ENV_W    = DEF_ENV_W
) ();

    logic                       keyOn;
    logic [3:0]                 keyVal;
    logic signed [SAMPLE_W-1:0] sampleIn;
    logic signed [SAMPLE_W-1:0] sampleOut;
    logic                       outValid;
    logic [ENV_W-1:0]           envLevel;
    env_state_t                 envState;

    modport master (
        output keyOn,
        output keyVal,
        output sampleIn,
        input  sampleOut,
        input  outValid,
        input  envLevel,
        input  envState
    );

    modport slave (
        input  keyOn,
        input  keyVal,
        input  sampleIn,
        output sampleOut,
        output outValid,
        output envLevel,
        output envState
    );

endinterface

// File: rtl/adsr_envelope_lrck_tick_gen.sv
// Brings the codec DAC LR clock into the clk_50 domain and emits one clk_50 pulse
// per frame on its rising edge.
module lrck_tick_gen (
    input  logic clk_50,
    input  logic ar,
    input  logic daclrck,
    output logic tick
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // Two flops for metastability, a third to find the rising edge.
    always_ff @(posedge clk_50 or posedge ar) begin
        if (ar) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= daclrck;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope stepped once per DAC frame, scaling the wavetable sample.
// Define ADSR_EXP_RELEASE_EN for an exponential release instead of the linear one.
module adsr_envelope
    import synth_pkg::*;
#(
    parameter int SAMPLE_W      = DEF_SAMPLE_W,
    parameter int ENV_W         = DEF_ENV_W,
    parameter int ATTACK_STEP   = DEF_ATTACK_STEP,
    parameter int DECAY_STEP    = DEF_DECAY_STEP,
    parameter int SUSTAIN_LVL   = DEF_SUSTAIN_LVL,
    parameter int RELEASE_STEP  = DEF_RELEASE_STEP,
    parameter int RELEASE_SHIFT = DEF_RELEASE_SHIFT
) (
    input  logic             clk_50,
    input  logic             ar,
    input  logic             daclrck,
    adsr_envelope_if.slave   bus
);

    localparam int PROD_W = SAMPLE_W + ENV_W + 1;

    localparam logic [ENV_W:0] ENV_MAX_X   = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W:0] ATTACK_X    = (ENV_W+1)'(ATTACK_STEP);
    localparam logic [ENV_W:0] DECAY_X     = (ENV_W+1)'(DECAY_STEP);
    localparam logic [ENV_W:0] SUSTAIN_X   = (ENV_W+1)'(SUSTAIN_LVL);
    localparam logic [ENV_W:0] RELEASE_X   = (ENV_W+1)'(RELEASE_STEP);

    if (longint'(SUSTAIN_LVL) > longint'(envMax(ENV_W)) ||
        longint'(RELEASE_STEP) > longint'(envMax(ENV_W)) ||
        RELEASE_SHIFT >= ENV_W) begin : gBadParams
        $error("adsr_envelope: step/level parameters out of range for ENV_W");
    end

    logic tick;

    lrck_tick_gen uTickGen (
        .clk_50  (clk_50),
        .ar      (ar),
        .daclrck (daclrck),
        .tick    (tick)
    );

    env_state_t                 state_q,     state_d;
    logic [ENV_W-1:0]           env_q,       env_d;
    logic                       pressPend_q, pressPend_d;
    logic                       relPend_q,   relPend_d;
    logic                       keyOnPrev_q;
    logic [3:0]                 keyValPrev_q;
    logic signed [SAMPLE_W-1:0] s_q;
    logic                       outValid_q;

    logic           pressNow;
    logic           relNow;
    logic           pressEff;
    logic           relEff;
    logic           active;
    logic [ENV_W:0] envX;
    logic [ENV_W:0] attackSum;
    logic [ENV_W:0] decayDiff;
    logic [ENV_W:0] relAmt;
    logic [ENV_W:0] relDiff;

    assign pressNow = bus.keyOn && (!keyOnPrev_q || (bus.keyVal != keyValPrev_q));
    assign relNow   = !bus.keyOn && keyOnPrev_q;
    assign pressEff = pressPend_q | pressNow;
    assign relEff   = relPend_q | relNow;

    assign envX      = {1'b0, env_q};
    assign attackSum = envX + ATTACK_X;
    assign decayDiff = envX - DECAY_X;
`ifdef ADSR_EXP_RELEASE_EN
    assign relAmt    = (envX >> RELEASE_SHIFT) + {{ENV_W{1'b0}}, 1'b1};
`else
    assign relAmt    = RELEASE_X;
`endif
    assign relDiff   = envX - relAmt;

    always_comb begin
        state_d     = state_q;
        env_d       = env_q;
        pressPend_d = pressEff;
        // A later press in the frame supersedes an earlier release.
        relPend_d   = pressNow ? 1'b0 : relEff;
        active      = 1'b0;

        if (tick) begin
            active      = (state_q != IDLE) || pressEff;
            pressPend_d = 1'b0;
            if (pressEff) begin
                state_d = ATTACK;
            end else if (relEff || (!bus.keyOn &&
                         (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN))) begin
                state_d   = RELEASE;
                relPend_d = 1'b0;
            end else begin
                relPend_d = 1'b0;
                unique case (state_q)
                    ATTACK: begin
                        if (attackSum >= ENV_MAX_X) begin
                            env_d   = ENV_MAX_X[ENV_W-1:0];
                            state_d = DECAY;
                        end else begin
                            env_d = attackSum[ENV_W-1:0];
                        end
                    end
                    DECAY: begin
                        if (decayDiff[ENV_W] || decayDiff <= SUSTAIN_X) begin
                            env_d   = SUSTAIN_X[ENV_W-1:0];
                            state_d = SUSTAIN;
                        end else begin
                            env_d = decayDiff[ENV_W-1:0];
                        end
                    end
                    SUSTAIN: begin
                        env_d = env_q;
                    end
                    RELEASE: begin
                        if (relDiff[ENV_W] || relDiff == '0) begin
                            env_d   = '0;
                            state_d = IDLE;
                        end else begin
                            env_d = relDiff[ENV_W-1:0];
                        end
                    end
                    default: begin
                        env_d   = '0;
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_50 or posedge ar) begin
        if (ar) begin
            state_q      <= IDLE;
            env_q        <= '0;
            pressPend_q  <= 1'b0;
            relPend_q    <= 1'b0;
            keyOnPrev_q  <= 1'b0;
            keyValPrev_q <= '0;
            s_q          <= '0;
            outValid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            env_q        <= env_d;
            pressPend_q  <= pressPend_d;
            relPend_q    <= relPend_d;
            keyOnPrev_q  <= bus.keyOn;
            keyValPrev_q <= bus.keyVal;
            outValid_q   <= active;
            if (active) begin
                s_q <= bus.sampleIn;
            end
        end
    end

    // s_q and env_q only move on a tick, so the scaled sample holds between frames.
    logic signed [PROD_W-1:0] product;
    logic                     unusedProdBits;

    assign product        = s_q * $signed({1'b0, env_q});
    assign unusedProdBits = ^{product[ENV_W-1:0], product[PROD_W-1]};

    assign bus.sampleOut = product[ENV_W+SAMPLE_W-1:ENV_W];
    assign bus.outValid  = outValid_q;
    assign bus.envLevel  = env_q;
    assign bus.envState  = state_q;

endmodule
